// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: GF(2^8) constant multipliers, state byte
// indexing and the round-stage FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // MSB position of byte s[r][c] in the row-major 128-bit state
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return 127 - 8 * (4 * r + c);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one state column; byte for row 0 sits in
// bits [31:24].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
    assign col_out[23:16] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
    assign col_out[15:8]  = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
    assign col_out[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock, En/Ry handshake.
// Optional macro INV_MIX_BYPASS_EN adds a Bypass input for the final round.
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         En,
`ifdef INV_MIX_BYPASS_EN
    input  logic         Bypass,
`endif
    input  logic [127:0] Text,
    output logic         Ry,
    output logic [127:0] ModifiedText
);

    localparam int N = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t       state, state_nxt;
    logic [1:0]   cnt;
    logic [127:0] work, work_nxt;
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];
    logic         last;
    logic         bypass_sel;

`ifdef INV_MIX_BYPASS_EN
    assign bypass_sel = Bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    // cnt is always a multiple of COLS_PER_CYCLE, so cnt+k never passes column 3
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_in[k] = '0;
            for (int r = 0; r < 4; r++) begin
                col_in[k][31-8*r -: 8] = work[idx(r, int'(cnt) + k) -: 8];
            end
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        inv_mix_column u_col (
            .col_in  (col_in[k]),
            .col_out (col_out[k])
        );
    end

    always_comb begin
        work_nxt = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int r = 0; r < 4; r++) begin
                work_nxt[idx(r, int'(cnt) + k) -: 8] = col_out[k][31-8*r -: 8];
            end
        end
    end

    assign last = (({1'b0, cnt} + 3'(COLS_PER_CYCLE)) == 3'd4);
    assign Ry   = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (En) state_nxt = bypass_sel ? DONE : RUN;
            RUN:     if (!En) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    if (!En) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            work         <= '0;
            ModifiedText <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (En) begin
                    work <= Text;
                    cnt  <= '0;
                    if (bypass_sel) ModifiedText <= Text;
                end
                RUN: if (En) begin
                    work <= work_nxt;
                    cnt  <= cnt + STEP;
                    if (last) ModifiedText <= work_nxt;
                end
                default: ;
            endcase
        end
    end

    logic unused_n;
    assign unused_n = (N == 0);

endmodule
